// File: rtl/axi_lite_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_master_bridge
//  Description : Bridges a simple command/response handshake onto an AXI4-Lite
//                master port. One transaction is in flight at a time: a
//                command is latched, driven out as AW+W or AR, the B or R
//                response is captured and then presented on the response
//                port until it is consumed.
//  Revision    : 1.0 - initial release
//
//  Optional feature macro : AXIM_TIMEOUT_EN
//    Defined   -> a response-wait counter aborts WR_RESP/RD_RESP after
//                 TIMEOUT_CYCLES cycles, reporting rsp_resp = 2'b11.
//    Undefined -> no counter; the bridge waits for B/R indefinitely.
//
//  Parameters
//    TIMEOUT_CYCLES : response-wait limit in cycles (timeout build only)
//
//  Ports
//    ACLK, ARESETn             : clock (rising edge), async active-low reset
//    cmd_valid/cmd_ready       : command handshake
//    cmd_write                 : 1 = write, 0 = read
//    cmd_addr/wdata/wstrb      : command payload
//    rsp_valid/rsp_ready       : response handshake
//    rsp_write/rdata/resp      : response payload (rdata = 0 for writes,
//                                resp = 2'b11 on timeout)
//    AW*/W*/B*/AR*/R*          : AXI4-Lite master channels
// ============================================================================
module axi_lite_master_bridge #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  // command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  // response side
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  // AXI4-Lite write address
  output logic [31:0] AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  // AXI4-Lite write data
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  // AXI4-Lite write response
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  // AXI4-Lite read address
  output logic [31:0] ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  // AXI4-Lite read data
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  localparam logic [1:0] c_RESP_TIMEOUT = 2'b11;

  // The counter compare needs at least one cycle of wait.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_param
    $error("axi_lite_master_bridge: TIMEOUT_CYCLES must be >= 1");
  end

  logic [2:0]  r_state;
  logic        r_cmd_ready;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_arvalid;
  logic        r_bready;
  logic        r_rready;
  logic        r_rsp_valid;
  logic        r_rsp_write;
  logic [31:0] r_rsp_rdata;
  logic [1:0]  r_rsp_resp;

  logic w_accept;
  logic w_aw_done;
  logic w_w_done;
  logic w_b_hs;
  logic w_r_hs;
  logic w_timeout;

  assign w_accept  = cmd_valid && r_cmd_ready;
  // A channel is done once its VALID has dropped, or it is handshaking now.
  assign w_aw_done = !r_awvalid || AWREADY;
  assign w_w_done  = !r_wvalid  || WREADY;
  assign w_b_hs    = BVALID && r_bready;
  assign w_r_hs    = RVALID && r_rready;

`ifdef AXIM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tcnt;
  logic          w_in_resp;

  assign w_in_resp = (r_state == S_WR_RESP) || (r_state == S_RD_RESP);

  // Held at zero outside the response states, so every entry starts from 0.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_tcnt <= '0;
    end else if (w_in_resp) begin
      r_tcnt <= r_tcnt + TW'(1);
    end else begin
      r_tcnt <= '0;
    end
  end

  // Fires on the last waiting cycle so RSP is entered exactly
  // TIMEOUT_CYCLES cycles after the response state was entered.
  assign w_timeout = w_in_resp && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_write     <= cmd_write;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
            r_wstrb     <= cmd_wstrb;
            if (cmd_write) begin
              r_state   <= S_WR_REQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= S_RD_REQ;
              r_arvalid <= 1'b1;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        S_WR_REQ: begin
          if (r_awvalid && AWREADY) begin
            r_awvalid <= 1'b0;
          end
          if (r_wvalid && WREADY) begin
            r_wvalid <= 1'b0;
          end
          if (w_aw_done && w_w_done) begin
            r_state  <= S_WR_RESP;
            r_bready <= 1'b1;
          end
        end

        S_WR_RESP: begin
          if (w_b_hs) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= BRESP;
            r_rsp_rdata <= '0;
            r_rsp_write <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end else if (w_timeout) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= c_RESP_TIMEOUT;
            r_rsp_rdata <= '0;
            r_rsp_write <= r_write;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end

        S_RD_REQ: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_RESP;
          end
        end

        S_RD_RESP: begin
          if (w_r_hs) begin
            r_rready    <= 1'b0;
            r_rsp_resp  <= RRESP;
            r_rsp_rdata <= RDATA;
            r_rsp_write <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end else if (w_timeout) begin
            r_rready    <= 1'b0;
            r_rsp_resp  <= c_RESP_TIMEOUT;
            r_rsp_rdata <= '0;
            r_rsp_write <= r_write;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end

        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b0;
          r_awvalid   <= 1'b0;
          r_wvalid    <= 1'b0;
          r_arvalid   <= 1'b0;
          r_bready    <= 1'b0;
          r_rready    <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;
  assign AWADDR    = r_addr;
  assign AWVALID   = r_awvalid;
  assign WDATA     = r_wdata;
  assign WSTRB     = r_wstrb;
  assign WVALID    = r_wvalid;
  assign BREADY    = r_bready;
  assign ARADDR    = r_addr;
  assign ARVALID   = r_arvalid;
  assign RREADY    = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_master_bridge
//  Description : Bench for axi_lite_master_bridge. Pairs the bridge with a
//                behavioural AXI4-Lite register-file slave (64 words at
//                0x000-0x0FC, SLVERR on unaligned/out-of-range addresses,
//                random ready/response delays) and checks every response
//                against an abstract memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master_bridge;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axi_lite_master_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------------------------------------------------------- slave
  logic        sl_block_aw = 1'b0;   // hold AWREADY low
  logic        sl_stall_b  = 1'b0;   // never answer writes
  logic [31:0] sl_last_addr;
  logic [31:0] sl_mem [0:63];
  logic        sl_aw_got, sl_w_got, sl_b_pend, sl_r_pend;
  logic [31:0] sl_awaddr, sl_wdata;
  logic [3:0]  sl_wstrb;
  logic [1:0]  sl_b_dly, sl_r_dly;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h100);
  endfunction

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      AWREADY <= 1'b0; WREADY <= 1'b0; BVALID <= 1'b0; BRESP <= 2'b00;
      ARREADY <= 1'b0; RVALID <= 1'b0; RDATA <= '0; RRESP <= 2'b00;
      sl_aw_got <= 1'b0; sl_w_got <= 1'b0; sl_b_pend <= 1'b0; sl_r_pend <= 1'b0;
      sl_awaddr <= '0; sl_wdata <= '0; sl_wstrb <= '0;
      sl_b_dly <= '0; sl_r_dly <= '0; sl_last_addr <= '0;
      for (int i = 0; i < 64; i++) sl_mem[i] <= '0;
    end else begin
      if (AWVALID && AWREADY) begin
        sl_aw_got <= 1'b1; sl_awaddr <= AWADDR; sl_last_addr <= AWADDR; AWREADY <= 1'b0;
      end else if (!sl_aw_got) begin
        AWREADY <= !sl_block_aw && ($urandom_range(0, 1) == 1);
      end
      if (WVALID && WREADY) begin
        sl_w_got <= 1'b1; sl_wdata <= WDATA; sl_wstrb <= WSTRB; WREADY <= 1'b0;
      end else if (!sl_w_got) begin
        WREADY <= ($urandom_range(0, 1) == 1);
      end
      if (sl_aw_got && sl_w_got && !sl_b_pend) begin
        sl_aw_got <= 1'b0; sl_w_got <= 1'b0; sl_b_pend <= 1'b1;
        sl_b_dly  <= 2'($urandom_range(0, 3));
        BRESP     <= addr_bad(sl_awaddr) ? 2'b10 : 2'b00;
        if (!addr_bad(sl_awaddr) && !sl_stall_b) begin
          for (int i = 0; i < 4; i++)
            if (sl_wstrb[i]) sl_mem[sl_awaddr[7:2]][8*i +: 8] <= sl_wdata[8*i +: 8];
        end
      end
      if (sl_b_pend && !BVALID) begin
        if (sl_stall_b) sl_b_pend <= 1'b0;
        else if (sl_b_dly == 2'd0) BVALID <= 1'b1;
        else sl_b_dly <= sl_b_dly - 2'd1;
      end
      if (BVALID && BREADY) begin
        BVALID <= 1'b0; sl_b_pend <= 1'b0;
      end
      if (ARVALID && ARREADY) begin
        ARREADY <= 1'b0; sl_r_pend <= 1'b1; sl_last_addr <= ARADDR;
        sl_r_dly <= 2'($urandom_range(0, 3));
        RRESP <= addr_bad(ARADDR) ? 2'b10 : 2'b00;
        RDATA <= addr_bad(ARADDR) ? 32'h0 : sl_mem[ARADDR[7:2]];
      end else if (!sl_r_pend) begin
        ARREADY <= ($urandom_range(0, 1) == 1);
      end
      if (sl_r_pend && !RVALID) begin
        if (sl_r_dly == 2'd0) RVALID <= 1'b1;
        else sl_r_dly <= sl_r_dly - 2'd1;
      end
      if (RVALID && RREADY) begin
        RVALID <= 1'b0; sl_r_pend <= 1'b0;
      end
    end
  end

  // ----------------------------------------------------- reference model
  logic [31:0] ref_mem [0:63];

  task automatic ref_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
  endtask

  // Register file semantics: aligned in-range -> OKAY; anything else ->
  // SLVERR with no side effect and zero read data.
  task automatic ref_apply(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] erd, output logic [1:0] eresp);
    logic [31:0] mask;
    erd = 32'h0;
    if ((a % 4) != 0 || a >= 32'd256) begin
      eresp = 2'b10;
      return;
    end
    eresp = 2'b00;
    if (w) begin
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      ref_mem[a / 4] = (ref_mem[a / 4] & ~mask) | (d & mask);
    end else begin
      erd = ref_mem[a / 4];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full command/response transaction, checked against the model.
  // 'hold' keeps rsp_ready low for that many cycles while a stray command
  // is pulsed, checking the response is frozen and the AXI side is quiet.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int hold, input string tag,
                     output logic [31:0] ard);
    logic [31:0] erd;
    logic [1:0]  eresp;
    int n;
    ard = 32'h0;
    ref_apply(w, a, d, s, erd, eresp);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
    if (!cmd_ready) begin
      check({tag, ".accept"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge ACLK);
    cmd_valid = 1'b0;
    if (w) begin
      check({tag, ".aw_w_valid"}, 32'(AWVALID & WVALID), 32'd1);
      check({tag, ".awaddr"}, AWADDR, a);
    end else begin
      check({tag, ".arvalid"}, 32'(ARVALID), 32'd1);
      check({tag, ".araddr"}, ARADDR, a);
    end
    check({tag, ".busy_cmd_ready"}, 32'(cmd_ready), 32'd0);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge ACLK); n++; end
    if (!rsp_valid) begin
      check({tag, ".rsp_timeout"}, 32'(rsp_valid), 32'd1);
      return;
    end
    ard = rsp_rdata;
    check({tag, ".resp"}, 32'(rsp_resp), 32'(eresp));
    check({tag, ".rdata"}, rsp_rdata, erd);
    check({tag, ".rwrite"}, 32'(rsp_write), 32'(w));
    check({tag, ".slave_addr"}, sl_last_addr, a);
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      cmd_valid = (i == 1); cmd_write = 1'b1; cmd_addr = 32'h4;
      check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".hold_rdata"}, rsp_rdata, erd);
      check({tag, ".hold_resp"}, 32'(rsp_resp), 32'(eresp));
      check({tag, ".hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
      check({tag, ".hold_axi_idle"}, 32'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    check({tag, ".post_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".post_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, ".post_axi_idle"}, 32'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        w;
    int          n, sel;

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    ARESETn = 1'b1;
    #2 ARESETn = 1'b0;
    ref_reset();
    @(negedge ACLK);
    @(negedge ACLK);
    check("rst.cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.valids", 32'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 32'd0);
    check("rst.awaddr", AWADDR, 32'h0);
    check("rst.rsp_payload", rsp_rdata | 32'(rsp_resp) | 32'(rsp_write), 32'h0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("rst.cmd_ready_after", 32'(cmd_ready), 32'd1);

    // Full-word write and read-back.
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "w10", rd);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, "r10", rd);
    check("r10.const", rd, 32'hDEADBEEF);

    // Byte-lane merge.
    txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0, "w20a", rd);
    txn(1'b1, 32'h20, 32'h0000AA00, 4'b0010, 0, "w20b", rd);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0, "r20", rd);
    check("r20.const", rd, 32'h1122AA44);

    // Unaligned and out-of-range pass through and report SLVERR.
    txn(1'b0, 32'h22, 32'h0, 4'h0, 0, "r22", rd);
    txn(1'b1, 32'h23, 32'h55555555, 4'hF, 0, "w23", rd);
    txn(1'b0, 32'h8000_0004, 32'h0, 4'h0, 0, "rfar", rd);

    // Response held for 5 cycles with a stray command pulse.
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5, "hold", rd);

    // Reset while AWVALID is up.
    sl_block_aw = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30;
    cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    check("arst.awvalid_before", 32'(AWVALID), 32'd1);
    #3 ARESETn = 1'b0;
    ref_reset();
    #1;
    check("arst.aw_w_valid", 32'({AWVALID, WVALID}), 32'd0);
    check("arst.rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    sl_block_aw = 1'b0;
    @(negedge ACLK);
    check("arst.cmd_ready_after", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("arst.quiet", 32'({rsp_valid, AWVALID, WVALID, ARVALID}), 32'd0);
    end
    txn(1'b0, 32'h30, 32'h0, 4'h0, 0, "r30", rd);

    // Randomized traffic concentrated on a few words so reads hit writes.
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      w   = 1'($urandom_range(0, 1));
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      if (sel < 7)       a = 32'($urandom_range(0, 15)) * 32'd4;
      else if (sel == 7) a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
      else               a = 32'h100 + 32'($urandom_range(0, 1023)) * 32'd4;
      txn(w, a, d, s, $urandom_range(0, 2), "rnd", rd);
    end

`ifdef AXIM_TIMEOUT_EN
    // Slave that never answers the write.
    sl_stall_b = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40;
    cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    n = 0;
    while (!BREADY && n < 50) begin @(negedge ACLK); n++; end
    check("to.bready_seen", 32'(BREADY), 32'd1);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge ACLK); n++; end
    check("to.latency", 32'(n), 32'd8);
    check("to.resp", 32'(rsp_resp), 32'd3);
    check("to.rdata", rsp_rdata, 32'h0);
    check("to.bready_dropped", 32'(BREADY), 32'd0);
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    check("to.idle_cmd_ready", 32'(cmd_ready), 32'd1);
    sl_stall_b = 1'b0;
    txn(1'b0, 32'h40, 32'h0, 4'h0, 0, "r40", rd);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_master_bridge.md
AXI_LITE_MASTER_BRIDGE -- requirements
Module: axi_lite_master_bridge

Interface
REQ-001 The block SHALL have one parameter, listed below.
- TIMEOUT_CYCLES, 256, cycles to wait in a response state before aborting; used only with AXIM_TIMEOUT_EN.

REQ-002 The block SHALL have the following ports, clock and reset first.
- ACLK  in  1  single clock; all logic on rising edge.
- ARESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte enables.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP or RRESP; 2'b11 on timeout.
- AWADDR/AWVALID/AWREADY  out/out/in  32/1/1  AXI4-Lite write address.
- WDATA/WSTRB/WVALID/WREADY  out/out/out/in  32/4/1/1  AXI4-Lite write data.
- BRESP/BVALID/BREADY  in/in/out  2/1/1  AXI4-Lite write response.
- ARADDR/ARVALID/ARREADY  out/out/in  32/1/1  AXI4-Lite read address.
- RDATA/RRESP/RVALID/RREADY  in/in/in/out  32/2/1/1  AXI4-Lite read data.

Function
REQ-003 The FSM SHALL have the states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and RSP, and the block SHALL carry one transaction at a time.
REQ-004 cmd_ready SHALL be 1 only in IDLE, and cmd_valid outside IDLE SHALL be ignored.
REQ-005 On cmd_valid&&cmd_ready the block SHALL latch addr/wdata/wstrb/write and go to WR_REQ (write) or RD_REQ (read).
REQ-006 In WR_REQ, AWVALID and WVALID SHALL both be high from the cycle after acceptance, with AWADDR/WDATA/WSTRB from the latched values and held stable.
REQ-007 Each of AWVALID and WVALID SHALL deassert independently the cycle after its own VALID&&READY edge.
REQ-008 When both AW and W handshakes are complete (same cycle or different cycles), the FSM SHALL enter WR_RESP with BREADY=1.
REQ-009 In WR_RESP, on BVALID&&BREADY the block SHALL capture BRESP into rsp_resp, set rsp_rdata=0 and rsp_write=1, drop BREADY, and go to RSP.
REQ-010 In RD_REQ, ARVALID SHALL be high with ARADDR stable until ARVALID&&ARREADY, then the FSM SHALL go to RD_RESP with RREADY=1.
REQ-011 In RD_RESP, on RVALID&&RREADY the block SHALL capture RDATA/RRESP, set rsp_write=0, drop RREADY, and go to RSP.
REQ-012 In RSP, rsp_valid SHALL be 1 with payload stable until rsp_ready, after which the FSM SHALL return to IDLE the next cycle.
REQ-013 Unaligned or out-of-range addresses SHALL pass through unchanged, and slave error responses SHALL be reported, not masked.
REQ-014 BREADY/RREADY SHALL never be asserted outside WR_RESP/RD_RESP.
REQ-015 The best-case write SHALL take 1 cycle from acceptance to AW/W VALID, and rsp_valid SHALL assert 1 cycle after the B/R handshake.

Reset
REQ-016 While ARESETn=0, all outputs SHALL be 0, the FSM SHALL be IDLE, and latched registers SHALL be cleared; cmd_ready SHALL go to 1 on the first clock after release.
REQ-017 Reset mid-transaction SHALL abort immediately, deasserting all VALID/READY outputs and discarding any pending response without emitting it.

Configuration
REQ-018 With macro AXIM_TIMEOUT_EN defined, a counter SHALL run in WR_RESP/RD_RESP and clear on state entry.
REQ-019 With AXIM_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES without a handshake, the block SHALL drop BREADY/RREADY, set rsp_resp=2'b11 and rsp_rdata=0, and go to RSP.
REQ-020 Without AXIM_TIMEOUT_EN, no counter SHALL exist and the block SHALL wait indefinitely.

Verification (bench pairs block with the team's AXI4-Lite register-file slave)
REQ-021 Write addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, then read addr=0x10 -> rsp_resp=0 for both; read rsp_rdata=0xDEADBEEF.
REQ-022 Write 0x11223344 to 0x20, then write wstrb=4'b0010 with wdata=0x0000AA00, then read 0x20 -> rsp_rdata=0x1122AA44.
REQ-023 Read addr=0x22 (unaligned) -> rsp_resp=2'b10, rsp_rdata=0.
REQ-024 Hold rsp_ready=0 for 5 cycles and pulse cmd_valid during RSP -> rsp_valid and payload stable, cmd_ready=0, no new AXI activity.
REQ-025 Assert ARESETn=0 while AWVALID=1 -> AWVALID/WVALID=0 asynchronously, no rsp_valid, cmd_ready=1 the first cycle after release.
REQ-026 With AXIM_TIMEOUT_EN and TIMEOUT_CYCLES=8, a stub slave that never asserts BVALID -> rsp_resp=2'b11 8 cycles after WR_RESP entry, then IDLE.
